serial_add2: RTL and testbench



---
 rtl/serial_add_pkg.sv | 19 +
 rtl/add2_slice.sv | 19 +
 rtl/serial_add2.sv | 110 +++++++++++
 tb/tb_serial_add2.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: enough to index WIDTH/2 digits, never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/add2_slice.sv
// Combinational 2-bit ripple adder built from two full adders.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic c1;

  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign cout = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);

endmodule

// File: rtl/serial_add2.sv
// Digit-serial adder: sequences a WIDTH-bit add through a 2-bit slice, 2 bits per cycle.
// Latency: WIDTH/2 cycles from input handshake to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module serial_add2
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int D  = WIDTH / 2;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [1:0]       slice_s;
  logic             slice_c;

  // The slice always looks at the current low digit and the running carry.
  add2_slice u_slice (
    .a    (a_q[1:0]),
    .b    (b_q[1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  // Next-state and datapath update: capture in IDLE, shift one digit per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New digit enters at the top; after D shifts the lowest digit lands at bit 0.
        sum_d              = sum_q >> 2;
        sum_d[WIDTH-1 -: 2] = slice_s;
        carry_d            = slice_c;
        a_d                = a_q >> 2;
        b_d                = b_q >> 2;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that discards any in-flight add.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_add2.sv
module tb_serial_add2;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;

  logic [1:0] sl_a, sl_b, sl_s;
  logic       sl_cin, sl_cout;

  int checks;
  int errors;

  serial_add2 #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  add2_slice u_slice_tb (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (sl_cin),
    .s    (sl_s),
    .cout (sl_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         hold;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for result, optional backpressure, handshake.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                        input int hold, input bit toggle,
                        output logic [7:0] s, output logic c);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    a         = ta;
    b         = tbv;
    cin       = tc;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (toggle) begin
        a        = 8'($urandom);
        b        = 8'($urandom);
        cin      = 1'($urandom);
        in_valid = 1'($urandom);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, 4);
    chk("in_ready_in_done", in_ready, 0);
    s = sum;
    c = cout;
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        a        = 8'hAA;
      end
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sum_stable", {23'b0, cout, sum}, {23'b0, c, s});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("in_ready_after_handshake", in_ready, 1);
    chk("out_valid_after_handshake", out_valid, 0);
  endtask

  initial begin
    vec_t       tbl [5];
    logic [7:0] s;
    logic       c;
    logic [8:0] ref_v;
    logic [2:0] sl_ref;
    int         n;
    logic [7:0] ra, rb;
    logic       rc;

    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    sl_a      = '0;
    sl_b      = '0;
    sl_cin    = 1'b0;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0};
    tbl[4] = '{8'h12, 8'h34, 1'b0, 5, 8'h46, 1'b0};

    // Slice stand-alone, exhaustive against plain addition.
    for (int i = 0; i < 32; i++) begin
      sl_a   = 2'(i);
      sl_b   = 2'(i >> 2);
      sl_cin = 1'(i >> 4);
      #1;
      sl_ref = 3'(sl_a) + 3'(sl_b) + 3'(sl_cin);
      chk("slice", {29'b0, sl_cout, sl_s}, {29'b0, sl_ref});
    end

    step();
    step();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    reset = 1'b0;
    step();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].hold, 1'b0, s, c);
      chk("vec_sum", s, tbl[i].sum);
      chk("vec_cout", c, tbl[i].cout);
    end
    // After the backpressure window with a=0xAA offered, nothing new was accepted.
    step();
    chk("no_accept_after_hold", in_ready, 1);
    chk("no_result_after_hold", out_valid, 0);

    // Operand/in_valid toggling during RUN does not disturb the accepted add.
    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b1, s, c);
    chk("toggle_sum", s, 8'h96);
    chk("toggle_cout", c, 0);

    // Reset on the second RUN cycle aborts the operation.
    a        = 8'h77;
    b        = 8'h11;
    cin      = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) n++;
    end
    chk("abort_no_output", n, 0);
    run_op(8'h01, 8'h01, 1'b0, 0, 1'b0, s, c);
    chk("post_abort_sum", s, 8'h02);
    chk("post_abort_cout", c, 0);

    // Random operands against arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rc    = 1'($urandom);
      ref_v = 9'(ra) + 9'(rb) + 9'(rc);
      run_op(ra, rb, rc, int'($urandom_range(0, 2)), 1'($urandom), s, c);
      chk("rand_sum", s, ref_v[7:0]);
      chk("rand_cout", c, ref_v[8]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
